// File: rtl/arp_lut_arb_pkg.sv
// Shared types and constants for the ARP LUT access arbiter.
package arp_lut_arb_pkg;

    localparam int unsigned MAC_W = 48;
    localparam int unsigned IP_W  = 32;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_grant #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arp_lut_access_arb.sv
// Round-robin sequencer sharing the single ARP LUT rd/wr port among NUM_REQ requesters.
// Optional ack watchdog enabled by defining ARP_LUT_ACCESS_TIMEOUT_EN.
module arp_lut_access_arb
    import arp_lut_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ            = 2,
    parameter int unsigned ARP_LUT_DEPTH_BITS = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ARP_LUT_DEPTH_BITS-1:0] req_addr,
    input  logic [NUM_REQ*48-1:0]           req_mac,
    input  logic [NUM_REQ*32-1:0]           req_ip,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [47:0]                     rsp_mac,
    output logic [31:0]                     rsp_ip,
    output logic                            rsp_err,
    output logic                            busy,
    output logic [ARP_LUT_DEPTH_BITS-1:0]   arp_rd_addr,
    output logic                            arp_rd_req,
    input  logic [47:0]                     arp_rd_mac,
    input  logic [31:0]                     arp_rd_ip,
    input  logic                            arp_rd_ack,
    output logic [ARP_LUT_DEPTH_BITS-1:0]   arp_wr_addr,
    output logic                            arp_wr_req,
    output logic [47:0]                     arp_wr_mac,
    output logic [31:0]                     arp_wr_ip,
    input  logic                            arp_wr_ack
`ifdef ARP_LUT_ACCESS_TIMEOUT_EN
    ,
    output logic [15:0]                     timeout_cnt
`endif
);

    localparam int unsigned A  = ARP_LUT_DEPTH_BITS;
    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               sel_wr;
    logic [A-1:0]       sel_addr;
    logic [MAC_W-1:0]   sel_mac;
    logic [IP_W-1:0]    sel_ip;

    logic [IW-1:0]      rr_ptr_q, grant_idx_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic               op_q;
    logic [A-1:0]       addr_q;
    logic [MAC_W-1:0]   mac_q;
    logic [IP_W-1:0]    ip_q;

    logic [A-1:0]       rd_addr_q, wr_addr_q;
    logic [MAC_W-1:0]   wr_mac_q, rsp_mac_q;
    logic [IP_W-1:0]    wr_ip_q, rsp_ip_q;
    logic               rd_req_q, wr_req_q, rsp_err_q;
    logic [NUM_REQ-1:0] done_q;

    logic               ack_hit, timeout_hit;

    rr_grant #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_grant (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Mux the grantee's request fields using the one-hot grant.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_mac  = '0;
        sel_ip   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[i*A +: A];
                sel_mac  = req_mac[i*MAC_W +: MAC_W];
                sel_ip   = req_ip[i*IP_W +: IP_W];
            end
        end
    end

    // Only the ack matching the latched operation counts, and only while waiting.
    assign ack_hit = (state_q == WAIT_ACK) && ((op_q == OP_WR) ? arp_wr_ack : arp_rd_ack);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pick_any) state_d = ISSUE;
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: if (ack_hit || timeout_hit) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            op_q        <= OP_RD;
            addr_q      <= '0;
            mac_q       <= '0;
            ip_q        <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_mac_q    <= '0;
            wr_ip_q     <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_mac_q   <= '0;
            rsp_ip_q    <= '0;
            rsp_err_q   <= 1'b0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx_q <= pick_idx;
                        grant_oh_q  <= pick_grant;
                        op_q        <= sel_wr;
                        addr_q      <= sel_addr;
                        mac_q       <= sel_mac;
                        ip_q        <= sel_ip;
                    end
                end
                ISSUE: begin
                    if (op_q == OP_WR) begin
                        wr_addr_q <= addr_q;
                        wr_mac_q  <= mac_q;
                        wr_ip_q   <= ip_q;
                        wr_req_q  <= 1'b1;
                    end else begin
                        rd_addr_q <= addr_q;
                        rd_req_q  <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit) begin
                        rd_req_q  <= 1'b0;
                        wr_req_q  <= 1'b0;
                        rsp_err_q <= 1'b0;
                        done_q    <= grant_oh_q;
                        if (op_q == OP_RD) begin
                            rsp_mac_q <= arp_rd_mac;
                            rsp_ip_q  <= arp_rd_ip;
                        end
                    end else if (timeout_hit) begin
                        rd_req_q  <= 1'b0;
                        wr_req_q  <= 1'b0;
                        rsp_err_q <= 1'b1;
                        rsp_mac_q <= '0;
                        rsp_ip_q  <= '0;
                        done_q    <= grant_oh_q;
                    end
                end
                DONE: begin
                    rr_ptr_q <= (grant_idx_q == IW'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARP_LUT_ACCESS_TIMEOUT_EN
    logic [15:0] wait_cnt_q, timeout_cnt_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive WAIT_ACK cycle without a matching ack.
    assign timeout_hit = (state_q == WAIT_ACK) && !ack_hit &&
                         (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT_ACK) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
            if (timeout_hit && (timeout_cnt_q != 16'hFFFF)) begin
                timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
        end
    end

    assign timeout_cnt = timeout_cnt_q;
`else
    logic unused_timeout_cfg;
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign req_done    = done_q;
    assign rsp_mac     = rsp_mac_q;
    assign rsp_ip      = rsp_ip_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != IDLE);
    assign arp_rd_addr = rd_addr_q;
    assign arp_rd_req  = rd_req_q;
    assign arp_wr_addr = wr_addr_q;
    assign arp_wr_req  = wr_req_q;
    assign arp_wr_mac  = wr_mac_q;
    assign arp_wr_ip   = wr_ip_q;

endmodule

// File: tb/tb_arp_lut_access_arb.sv
// Directed bench for arp_lut_access_arb (NUM_REQ=2, A=4, TIMEOUT_CYCLES=8).
module tb_arp_lut_access_arb;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [7:0]  req_addr;
    logic [95:0] req_mac;
    logic [63:0] req_ip;
    logic [1:0]  req_done;
    logic [47:0] rsp_mac;
    logic [31:0] rsp_ip;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  arp_rd_addr;
    logic        arp_rd_req;
    logic [47:0] arp_rd_mac;
    logic [31:0] arp_rd_ip;
    logic        arp_rd_ack;
    logic [3:0]  arp_wr_addr;
    logic        arp_wr_req;
    logic [47:0] arp_wr_mac;
    logic [31:0] arp_wr_ip;
    logic        arp_wr_ack;
`ifdef ARP_LUT_ACCESS_TIMEOUT_EN
    logic [15:0] timeout_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    arp_lut_access_arb #(
        .NUM_REQ           (2),
        .ARP_LUT_DEPTH_BITS(4),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_mac    (req_mac),
        .req_ip     (req_ip),
        .req_done   (req_done),
        .rsp_mac    (rsp_mac),
        .rsp_ip     (rsp_ip),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .arp_rd_addr(arp_rd_addr),
        .arp_rd_req (arp_rd_req),
        .arp_rd_mac (arp_rd_mac),
        .arp_rd_ip  (arp_rd_ip),
        .arp_rd_ack (arp_rd_ack),
        .arp_wr_addr(arp_wr_addr),
        .arp_wr_req (arp_wr_req),
        .arp_wr_mac (arp_wr_mac),
        .arp_wr_ip  (arp_wr_ip),
        .arp_wr_ack (arp_wr_ack)
`ifdef ARP_LUT_ACCESS_TIMEOUT_EN
        ,
        .timeout_cnt(timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a done pulse; returns 0 if the budget expires.
    task automatic wait_done(input int budget, output logic [1:0] seen);
        seen = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req_done != 2'b00) begin
                seen = req_done;
                break;
            end
        end
    endtask

    logic [1:0] seen;

    initial begin
        reset = 1'b0;  req_valid = '0;  req_wr = '0;  req_addr = '0;
        req_mac = '0;  req_ip = '0;     arp_rd_mac = '0;  arp_rd_ip = '0;
        arp_rd_ack = 1'b0;  arp_wr_ack = 1'b0;
        cyc(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_rd_req", 64'(arp_rd_req), 64'd0);
        check("rst_wr_req", 64'(arp_wr_req), 64'd0);
        check("rst_rsp_mac", 64'(rsp_mac), 64'd0);
        reset = 1'b1;
        cyc(1);

        // 1: single read, ack two cycles after req rises
        req_valid = 2'b01;  req_wr = 2'b00;  req_addr = 8'h03;
        cyc(1);
        check("t1_issue_busy", 64'(busy), 64'd1);
        check("t1_issue_rdreq", 64'(arp_rd_req), 64'd0);
        cyc(1);
        check("t1_rd_req", 64'(arp_rd_req), 64'd1);
        check("t1_rd_addr", 64'(arp_rd_addr), 64'd3);
        check("t1_wr_req", 64'(arp_wr_req), 64'd0);
        cyc(1);
        check("t1_rd_req_held", 64'(arp_rd_req), 64'd1);
        check("t1_no_done", 64'(req_done), 64'd0);
        arp_rd_ack = 1'b1;  arp_rd_mac = 48'h001122334455;  arp_rd_ip = 32'h0A000001;
        cyc(1);
        check("t1_done", 64'(req_done), 64'h1);
        check("t1_rd_req_drop", 64'(arp_rd_req), 64'd0);
        check("t1_rsp_mac", 64'(rsp_mac), 64'h001122334455);
        check("t1_rsp_ip", 64'(rsp_ip), 64'h0A000001);
        check("t1_err", 64'(rsp_err), 64'd0);
        arp_rd_ack = 1'b0;  req_valid = 2'b00;
        cyc(1);
        check("t1_done_once", 64'(req_done), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // 2: write from requester 1
        req_valid = 2'b10;  req_wr = 2'b10;  req_addr = 8'h70;
        req_mac = {48'hAABBCCDDEEFF, 48'h0};  req_ip = {32'hC0A80101, 32'h0};
        cyc(2);
        check("t2_wr_req", 64'(arp_wr_req), 64'd1);
        check("t2_wr_addr", 64'(arp_wr_addr), 64'd7);
        check("t2_wr_mac", 64'(arp_wr_mac), 64'hAABBCCDDEEFF);
        check("t2_wr_ip", 64'(arp_wr_ip), 64'hC0A80101);
        check("t2_rd_req", 64'(arp_rd_req), 64'd0);
        check("t2_rd_addr_hold", 64'(arp_rd_addr), 64'd3);
        cyc(1);
        check("t2_wr_req_held", 64'(arp_wr_req), 64'd1);
        arp_wr_ack = 1'b1;
        cyc(1);
        check("t2_done", 64'(req_done), 64'h2);
        check("t2_wr_req_drop", 64'(arp_wr_req), 64'd0);
        check("t2_rsp_mac_kept", 64'(rsp_mac), 64'h001122334455);
        check("t2_rsp_ip_kept", 64'(rsp_ip), 64'h0A000001);
        arp_wr_ack = 1'b0;  req_valid = 2'b00;  req_wr = 2'b00;
        cyc(1);

        // 3: contention, reads with ack always present; grants alternate from 0
        req_valid = 2'b11;  req_addr = 8'h5A;
        arp_rd_ack = 1'b1;  arp_rd_mac = 48'h123456789ABC;  arp_rd_ip = 32'h01020304;
        for (int n = 0; n < 6; n++) begin
            wait_done(10, seen);
            check("t3_grant", 64'(seen), (n % 2 == 0) ? 64'h1 : 64'h2);
            check("t3_rd_addr", 64'(arp_rd_addr), (n % 2 == 0) ? 64'hA : 64'h5);
        end
        req_valid = 2'b00;  arp_rd_ack = 1'b0;
        cyc(1);

        // 4: stray acks
        arp_rd_ack = 1'b1;
        cyc(1);
        check("t4_idle_ack_busy", 64'(busy), 64'd0);
        check("t4_idle_ack_done", 64'(req_done), 64'd0);
        arp_rd_ack = 1'b0;  req_valid = 2'b01;  req_addr = 8'h0C;
        cyc(2);
        check("t4_rd_req", 64'(arp_rd_req), 64'd1);
        arp_wr_ack = 1'b1;
        cyc(1);
        check("t4_wrack_ignored", 64'(arp_rd_req), 64'd1);
        check("t4_wrack_no_done", 64'(req_done), 64'd0);
        check("t4_wrack_busy", 64'(busy), 64'd1);
        arp_wr_ack = 1'b0;  arp_rd_ack = 1'b1;  arp_rd_mac = 48'hCAFE00000001;
        cyc(1);
        check("t4_done", 64'(req_done), 64'h1);
        check("t4_rsp_mac", 64'(rsp_mac), 64'hCAFE00000001);
        check("t4_rd_addr", 64'(arp_rd_addr), 64'hC);
        arp_rd_ack = 1'b0;  req_valid = 2'b00;
        cyc(2);

        // 5: no ack at all
        req_valid = 2'b01;
        cyc(1);
`ifdef ARP_LUT_ACCESS_TIMEOUT_EN
        cyc(8);
        check("t5_req_before_to", 64'(arp_rd_req), 64'd1);
        check("t5_no_done_yet", 64'(req_done), 64'd0);
        cyc(1);
        check("t5_to_done", 64'(req_done), 64'h1);
        check("t5_to_err", 64'(rsp_err), 64'd1);
        check("t5_to_req_drop", 64'(arp_rd_req), 64'd0);
        check("t5_to_rsp_mac", 64'(rsp_mac), 64'd0);
        check("t5_to_rsp_ip", 64'(rsp_ip), 64'd0);
        check("t5_to_cnt", 64'(timeout_cnt), 64'd1);
        req_valid = 2'b00;
        cyc(2);
        req_valid = 2'b01;
        cyc(2);
`else
        cyc(9);
        check("t5_stuck_req", 64'(arp_rd_req), 64'd1);
        check("t5_stuck_busy", 64'(busy), 64'd1);
        check("t5_stuck_no_done", 64'(req_done), 64'd0);
        check("t5_err_tied", 64'(rsp_err), 64'd0);
`endif

        // 6: reset during WAIT_ACK
        check("t6_pre_rd_req", 64'(arp_rd_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rd_req", 64'(arp_rd_req), 64'd0);
        check("t6_rst_rd_addr", 64'(arp_rd_addr), 64'd0);
        check("t6_rst_rsp_mac", 64'(rsp_mac), 64'd0);
        check("t6_rst_done", 64'(req_done), 64'd0);
        cyc(2);
        check("t6_rst_no_done", 64'(req_done), 64'd0);
        req_valid = 2'b11;  req_addr = 8'h5A;  arp_rd_ack = 1'b1;
        reset = 1'b1;
        wait_done(10, seen);
        check("t6_first_grant", 64'(seen), 64'h1);
        req_valid = 2'b00;  arp_rd_ack = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
